// File: rtl/takeoff_cmd_rx.sv
// rtl/takeoff_cmd_rx.sv - takeoff command frame receiver with sync hunt, checksum/range check and ACK/NAK
// Optional inter-byte timeout abort compiled in with `define TAKEOFF_RX_TIMEOUT_EN.
module takeoff_cmd_rx #(
    parameter logic [15:0] MAX_ALT     = 16'd1200,
    parameter int          TIMEOUT_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        cmd_valid,
    output logic [15:0] cmd_alt,
    output logic        ack_valid,
    output logic [7:0]  ack_code,
    output logic [7:0]  err_count
);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_ID    = 8'h01;
    localparam logic [7:0] LEN_VAL   = 8'h02;
    localparam logic [7:0] CODE_ACK  = 8'h06;
    localparam logic [7:0] CODE_CSUM = 8'h15;
    localparam logic [7:0] CODE_TOUT = 8'h18;
    localparam logic [7:0] CODE_RNG  = 8'h1A;

    typedef enum logic [2:0] {
        S_SYNC, S_CMD, S_LEN, S_ALT_HI, S_ALT_LO, S_CSUM, S_RESP
    } state_t;

    state_t      state, state_nxt;
    logic        xfer;
    logic        timeout_hit;
    logic        frame_done;
    logic        csum_ok;
    logic        alt_ok;
    logic        nak;
    logic [7:0]  csum_acc;
    logic [15:0] alt_hold;

    assign in_ready   = (state != S_RESP);
    assign xfer       = in_valid & in_ready;
    assign frame_done = xfer && (state == S_CSUM);
    assign csum_ok    = (in_data == csum_acc);
    assign alt_ok     = (alt_hold <= MAX_ALT);
    assign nak        = timeout_hit || (frame_done && !(csum_ok && alt_ok));

`ifdef TAKEOFF_RX_TIMEOUT_EN
    logic [15:0] idle_cnt;
    logic        mid_frame;

    assign mid_frame   = (state != S_SYNC) && (state != S_RESP);
    assign timeout_hit = mid_frame && !xfer && (idle_cnt == 16'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= 16'd0;
        end else if (xfer || !mid_frame) begin
            idle_cnt <= 16'd0;
        end else begin
            idle_cnt <= idle_cnt + 16'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // Foreign command IDs and bad lengths drop back to hunting without a NAK.
    always_comb begin
        state_nxt = state;
        case (state)
            S_SYNC:   if (xfer && in_data == SYNC_BYTE) state_nxt = S_CMD;
            S_CMD:    if (xfer) state_nxt = (in_data == CMD_ID)  ? S_LEN    : S_SYNC;
            S_LEN:    if (xfer) state_nxt = (in_data == LEN_VAL) ? S_ALT_HI : S_SYNC;
            S_ALT_HI: if (xfer) state_nxt = S_ALT_LO;
            S_ALT_LO: if (xfer) state_nxt = S_CSUM;
            S_CSUM:   if (xfer) state_nxt = S_RESP;
            S_RESP:   state_nxt = S_SYNC;
            default:  state_nxt = S_SYNC;
        endcase
        if (timeout_hit) state_nxt = S_RESP;
    end

    // Response fields are registered on the checksum byte so they land in the RESP cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_acc  <= 8'd0;
            alt_hold  <= 16'd0;
            cmd_valid <= 1'b0;
            cmd_alt   <= 16'd0;
            ack_valid <= 1'b0;
            ack_code  <= 8'h00;
            err_count <= 8'd0;
        end else begin
            cmd_valid <= 1'b0;
            ack_valid <= 1'b0;
            if (xfer) begin
                case (state)
                    S_SYNC:   csum_acc <= 8'd0;
                    S_CMD:    csum_acc <= in_data;
                    S_LEN:    csum_acc <= csum_acc ^ in_data;
                    S_ALT_HI: begin
                        alt_hold[15:8] <= in_data;
                        csum_acc       <= csum_acc ^ in_data;
                    end
                    S_ALT_LO: begin
                        alt_hold[7:0] <= in_data;
                        csum_acc      <= csum_acc ^ in_data;
                    end
                    default: ;
                endcase
            end
            if (frame_done) begin
                ack_valid <= 1'b1;
                if (!csum_ok) begin
                    ack_code <= CODE_CSUM;
                end else if (!alt_ok) begin
                    ack_code <= CODE_RNG;
                end else begin
                    ack_code  <= CODE_ACK;
                    cmd_valid <= 1'b1;
                    cmd_alt   <= alt_hold;
                end
            end
            if (timeout_hit) begin
                ack_valid <= 1'b1;
                ack_code  <= CODE_TOUT;
            end
            if (nak && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

endmodule
